// File: rtl/mark1_pkg.sv
// mark1_pkg: shared definitions for the Mark 1 sequencer core.
// Holds the function-field opcode codes, the FSM state encoding shown on the
// oscilloscope bus, instruction field-offset helpers and the memory-op classifier.
package mark1_pkg;

    localparam int unsigned OPC_BITS = 6;

    localparam logic [OPC_BITS-1:0] OP_NOP = 6'b000000;
    localparam logic [OPC_BITS-1:0] OP_CMP = 6'b000101;
    localparam logic [OPC_BITS-1:0] OP_JMP = 6'b001101;
    localparam logic [OPC_BITS-1:0] OP_STA = 6'b010100;
    localparam logic [OPC_BITS-1:0] OP_LDA = 6'b100000;
    localparam logic [OPC_BITS-1:0] OP_Z   = 6'b100100;
    localparam logic [OPC_BITS-1:0] OP_ADD = 6'b101100;
    localparam logic [OPC_BITS-1:0] OP_SUB = 6'b100110;
    localparam logic [OPC_BITS-1:0] OP_NEG = 6'b110110;
    localparam logic [OPC_BITS-1:0] OP_SHR = 6'b111110;
    localparam logic [OPC_BITS-1:0] OP_LDB = 6'b011100;
    localparam logic [OPC_BITS-1:0] OP_HLT = 6'b111111;

    typedef enum logic [2:0] {
        ST_STOPPED = 3'd0,
        ST_INC     = 3'd1,
        ST_FETCH   = 3'd2,
        ST_DECODE  = 3'd3,
        ST_MEM     = 3'd4,
        ST_EXEC    = 3'd5
    } state_e;

    // LSB of the function field, which occupies the top bits of the word.
    function automatic int unsigned fn_lsb(int unsigned wl, int unsigned fb);
        return wl - fb;
    endfunction

    // LSB of the B-line select field, directly above the address field.
    function automatic int unsigned sel_lsb(int unsigned iab);
        return iab;
    endfunction

    function automatic logic is_mem_op(logic [OPC_BITS-1:0] op);
        case (op)
            OP_JMP, OP_STA, OP_LDA, OP_ADD,
            OP_SUB, OP_NEG, OP_SHR, OP_LDB: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mark1_alu.sv
// mark1_alu: combinational accumulator update for the EXEC state.
// Ports: op_i   function code
//        a_i    current accumulator
//        s_i    store operand latched in MEM
//        a_o    next accumulator value (WL-bit wrap, no overflow flag)
//        skip_o CMP skip request (A negative)
module mark1_alu
    import mark1_pkg::*;
#(
    parameter int unsigned WL = 20
) (
    input  logic [OPC_BITS-1:0] op_i,
    input  logic [WL-1:0]       a_i,
    input  logic [WL-1:0]       s_i,
    output logic [WL-1:0]       a_o,
    output logic                skip_o
);

    always_comb begin
        a_o    = a_i;
        skip_o = 1'b0;
        case (op_i)
            OP_NOP: ;
            OP_CMP: skip_o = a_i[WL-1];
            OP_LDA: a_o = s_i;
            OP_Z:   a_o = '0;
            OP_ADD: a_o = a_i + s_i;
            OP_SUB: a_o = a_i - s_i;
            OP_NEG: a_o = '0 - s_i;
            OP_SHR: a_o = $signed(s_i) >>> 1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mark1_core.sv
// mark1_core: fetch/decode/execute sequencer with accumulator, CI and B-lines,
// talking to the main store over a req/ack handshake.
// Ports: w_CLK/w_RST clock, synchronous active-high reset
//        w_PS start pulse, w_KSP stop request, w_KCC clear A (STOPPED only)
//        w_STEP single-step pulse (present only with MARK1_CORE_STEP_EN)
//        b_MS_ADDR/w_MS_REQ/w_MS_WE/b_MS_WDATA store request side (registered)
//        b_MS_RDATA/w_MS_ACK store response side
//        w_SL stop lamp, b_CI control register, b_A accumulator, b_STATE state code
// Build option: define MARK1_CORE_STEP_EN for single-step operation.
module mark1_core
    import mark1_pkg::*;
#(
    parameter int unsigned WORD_LENGTH         = 20,
    parameter int unsigned INSTR_ADDR_BITS     = 10,
    parameter int unsigned INSTR_B_BITS        = 1,
    parameter int unsigned INSTR_FUNCTION_BITS = 6
) (
    input  logic                       w_CLK,
    input  logic                       w_RST,
    input  logic                       w_PS,
    input  logic                       w_KSP,
    input  logic                       w_KCC,
`ifdef MARK1_CORE_STEP_EN
    input  logic                       w_STEP,
`endif
    output logic [INSTR_ADDR_BITS-1:0] b_MS_ADDR,
    output logic                       w_MS_REQ,
    output logic                       w_MS_WE,
    output logic [WORD_LENGTH-1:0]     b_MS_WDATA,
    input  logic [WORD_LENGTH-1:0]     b_MS_RDATA,
    input  logic                       w_MS_ACK,
    output logic                       w_SL,
    output logic [INSTR_ADDR_BITS-1:0] b_CI,
    output logic [WORD_LENGTH-1:0]     b_A,
    output logic [2:0]                 b_STATE
);

    localparam int unsigned IAB    = INSTR_ADDR_BITS;
    localparam int unsigned IBB    = INSTR_B_BITS;
    localparam int unsigned WL     = WORD_LENGTH;
    localparam int unsigned N_B    = 2 ** IBB;
    localparam int unsigned FN_LSB = fn_lsb(WL, INSTR_FUNCTION_BITS);
    localparam int unsigned SEL_LSB = sel_lsb(IAB);
    localparam logic [IAB-1:0] CI_ONE = IAB'(1);

    state_e          state_q;
    logic [IAB-1:0]  ci_q;
    logic [WL-1:0]   a_q;
    logic [WL-1:0]   ir_q;
    logic [WL-1:0]   s_q;
    logic [IAB-1:0]  b_q [N_B];
    logic            req_q;
    logic            we_q;
    logic [IAB-1:0]  addr_q;
    logic [WL-1:0]   wdata_q;
    logic            sl_q;
    logic            stop_q;
`ifdef MARK1_CORE_STEP_EN
    logic            step_q;
`endif

    logic [OPC_BITS-1:0] op;
    logic [IBB-1:0]      sel;
    logic [IAB-1:0]      b_rd;
    logic [IAB-1:0]      ea_d;
    logic [IAB-1:0]      ci_inc;
    logic [WL-1:0]       alu_a;
    logic                alu_skip;
    logic                unused_ir;

    assign op        = ir_q[FN_LSB +: OPC_BITS];
    assign sel       = ir_q[SEL_LSB +: IBB];
    // B[0] is the hardwired zero line.
    assign b_rd      = (sel == '0) ? '0 : b_q[sel];
    assign ea_d      = ir_q[IAB-1:0] + b_rd;
    assign ci_inc    = ci_q + CI_ONE;
    assign unused_ir = ^ir_q;

    mark1_alu #(.WL(WL)) u_alu (
        .op_i   (op),
        .a_i    (a_q),
        .s_i    (s_q),
        .a_o    (alu_a),
        .skip_o (alu_skip)
    );

    always_ff @(posedge w_CLK) begin
        if (w_RST) begin
            state_q <= ST_STOPPED;
            ci_q    <= '0;
            a_q     <= '0;
            ir_q    <= '0;
            s_q     <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sl_q    <= 1'b1;
            stop_q  <= 1'b0;
            for (int unsigned i = 0; i < N_B; i++) b_q[i] <= '0;
`ifdef MARK1_CORE_STEP_EN
            step_q  <= 1'b0;
`endif
        end else begin
            // Stop requests are remembered in any running state; STOPPED and
            // the end of EXEC override this below.
            if (state_q != ST_STOPPED && w_KSP) stop_q <= 1'b1;

            case (state_q)
                ST_STOPPED: begin
                    stop_q <= 1'b0;
                    if (w_KCC) a_q <= '0;
                    if (w_PS && !w_KSP) begin
                        state_q <= ST_INC;
                        sl_q    <= 1'b0;
`ifdef MARK1_CORE_STEP_EN
                        step_q  <= 1'b0;
                    end else if (w_STEP && !w_KSP) begin
                        state_q <= ST_INC;
                        sl_q    <= 1'b0;
                        step_q  <= 1'b1;
`endif
                    end
                end
                ST_INC: begin
                    // Request is raised together with the FETCH state so a
                    // zero-wait store can acknowledge in the FETCH cycle.
                    ci_q    <= ci_inc;
                    addr_q  <= ci_inc;
                    req_q   <= 1'b1;
                    we_q    <= 1'b0;
                    state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (w_MS_ACK) begin
                        ir_q    <= b_MS_RDATA;
                        req_q   <= 1'b0;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (is_mem_op(op)) begin
                        addr_q  <= (op == OP_LDB) ? ir_q[IAB-1:0] : ea_d;
                        we_q    <= (op == OP_STA);
                        wdata_q <= a_q;
                        req_q   <= 1'b1;
                        state_q <= ST_MEM;
                    end else begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_MEM: begin
                    if (w_MS_ACK) begin
                        s_q     <= b_MS_RDATA;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    a_q <= alu_a;
                    if (op == OP_JMP)  ci_q <= s_q[IAB-1:0];
                    else if (alu_skip) ci_q <= ci_inc;
                    if (op == OP_LDB && sel != '0) b_q[sel] <= s_q[IAB-1:0];
                    if (op == OP_HLT || stop_q || w_KSP) begin
                        state_q <= ST_STOPPED;
                        sl_q    <= 1'b1;
                        stop_q  <= 1'b0;
`ifdef MARK1_CORE_STEP_EN
                        step_q  <= 1'b0;
                    end else if (step_q) begin
                        // Single-step pause: parked in STOPPED with the lamp off.
                        state_q <= ST_STOPPED;
`endif
                    end else begin
                        state_q <= ST_INC;
                    end
                end
                default: state_q <= ST_STOPPED;
            endcase
        end
    end

    assign b_MS_ADDR  = addr_q;
    assign w_MS_REQ   = req_q;
    assign w_MS_WE    = we_q;
    assign b_MS_WDATA = wdata_q;
    assign w_SL       = sl_q;
    assign b_CI       = ci_q;
    assign b_A        = a_q;
    assign b_STATE    = state_q;

endmodule
